// File: rtl/thread_lsu.sv
// thread_lsu: per-thread load/store unit driving a valid/ready memory handshake
package gpu_pkg;
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    DECODE  = 3'd2,
    REQUEST = 3'd3,
    WAIT    = 3'd4,
    EXECUTE = 3'd5,
    UPDATE  = 3'd6,
    DONE    = 3'd7
  } core_state_t;
endpackage

module thread_lsu
  import gpu_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  core_state_t           core_state,
  input  logic                  mem_read_en,
  input  logic                  mem_write_en,
  input  logic [DATA_WIDTH-1:0] rs_data,
  input  logic [DATA_WIDTH-1:0] rt_data,
  output logic                  mem_read_valid,
  output logic [ADDR_WIDTH-1:0] mem_read_address,
  input  logic                  mem_read_ready,
  input  logic [DATA_WIDTH-1:0] mem_read_data,
  output logic                  mem_write_valid,
  output logic [ADDR_WIDTH-1:0] mem_write_address,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  input  logic                  mem_write_ready,
  output logic [1:0]            lsu_state,
  output logic [DATA_WIDTH-1:0] lsu_result
);
  typedef enum logic [1:0] {S_IDLE, S_REQUESTING, S_WAITING, S_DONE} lsu_state_t;
  lsu_state_t st;
  logic is_read;
  logic ready;
  logic [ADDR_WIDTH-1:0] addr;
  assign addr = ADDR_WIDTH'(rs_data);
  assign ready = is_read ? mem_read_ready : mem_write_ready;
  assign lsu_state = st;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st                <= S_IDLE;
      is_read           <= 1'b0;
      mem_read_valid    <= 1'b0;
      mem_read_address  <= '0;
      mem_write_valid   <= 1'b0;
      mem_write_address <= '0;
      mem_write_data    <= '0;
      lsu_result        <= '0;
    end else begin
      case (st)
        S_IDLE: if (enable && core_state == REQUEST && (mem_read_en || mem_write_en)) begin
          st      <= S_REQUESTING;
          is_read <= mem_read_en;
          // a simultaneous STR is dropped in favour of the LDR
          if (mem_read_en) begin
            mem_read_valid   <= 1'b1;
            mem_read_address <= addr;
          end else begin
            mem_write_valid   <= 1'b1;
            mem_write_address <= addr;
            mem_write_data    <= rt_data;
          end
        end
        S_REQUESTING, S_WAITING: if (ready) begin
          st              <= S_DONE;
          mem_read_valid  <= 1'b0;
          mem_write_valid <= 1'b0;
          if (is_read) lsu_result <= mem_read_data;
        end else st <= S_WAITING;
        S_DONE: if (core_state == UPDATE) st <= S_IDLE;
        default: st <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_thread_lsu.sv
// tb_thread_lsu: randomized and directed checks of thread_lsu against a transaction-level model
module tb_thread_lsu;
  import gpu_pkg::*;
  logic clk = 0;
  logic rst_n;
  logic enable = 0;
  core_state_t core_state = IDLE;
  logic mem_read_en = 0, mem_write_en = 0;
  logic [7:0] rs_data = 0, rt_data = 0;
  logic mem_read_valid, mem_write_valid;
  logic [7:0] mem_read_address, mem_write_address, mem_write_data;
  logic mem_read_ready = 0, mem_write_ready = 0;
  logic [7:0] mem_read_data = 0;
  logic [1:0] lsu_state;
  logic [7:0] lsu_result;

  int tests = 0, fails = 0;
  int wait_n = 0;
  bit use_fixed = 0;
  logic [7:0] fixed_data = 0;
  bit armed = 0;
  int wv_cycles = 0;
  int seq[$];

  thread_lsu dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .core_state(core_state),
    .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
    .rs_data(rs_data), .rt_data(rt_data),
    .mem_read_valid(mem_read_valid), .mem_read_address(mem_read_address),
    .mem_read_ready(mem_read_ready), .mem_read_data(mem_read_data),
    .mem_write_valid(mem_write_valid), .mem_write_address(mem_write_address),
    .mem_write_data(mem_write_data), .mem_write_ready(mem_write_ready),
    .lsu_state(lsu_state), .lsu_result(lsu_result)
  );

  always #5 clk = ~clk;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: one in-flight record plus the last values presented on each bus.
  bit m_busy = 0, m_done = 0, m_rd = 0;
  int m_age = 0;
  logic [7:0] m_raddr = 0, m_waddr = 0, m_wdata = 0, m_result = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 0; m_done <= 0; m_rd <= 0; m_age <= 0;
      m_raddr <= 0; m_waddr <= 0; m_wdata <= 0; m_result <= 0;
    end else if (!m_busy) begin
      if (enable && core_state == REQUEST && (mem_read_en || mem_write_en)) begin
        m_busy <= 1; m_age <= 0; m_rd <= mem_read_en;
        if (mem_read_en) m_raddr <= rs_data;
        else begin m_waddr <= rs_data; m_wdata <= rt_data; end
      end
    end else if (!m_done) begin
      m_age <= m_age + 1;
      if (m_rd ? mem_read_ready : mem_write_ready) begin
        m_done <= 1;
        if (m_rd) m_result <= mem_read_data;
      end
    end else if (core_state == UPDATE) begin
      m_busy <= 0; m_done <= 0;
    end
  end

  always @(posedge clk) begin
    #1;
    if (armed && rst_n) begin
      check("state", 32'(lsu_state), !m_busy ? 0 : m_done ? 3 : (m_age == 0 ? 1 : 2));
      check("rvalid", 32'(mem_read_valid), 32'(m_busy && !m_done && m_rd));
      check("wvalid", 32'(mem_write_valid), 32'(m_busy && !m_done && !m_rd));
      check("raddr", 32'(mem_read_address), 32'(m_raddr));
      check("waddr", 32'(mem_write_address), 32'(m_waddr));
      check("wdata", 32'(mem_write_data), 32'(m_wdata));
      check("result", 32'(lsu_result), 32'(m_result));
      if (mem_write_valid) wv_cycles++;
    end
  end

  // Memory side: ready arrives wait_n cycles after valid; noise elsewhere must be ignored.
  int cnt = 0;
  always @(negedge clk) begin
    mem_read_data = use_fixed ? fixed_data : 8'($urandom);
    if (mem_read_valid || mem_write_valid) begin
      mem_read_ready  = mem_read_valid  ? (cnt == wait_n) : 1'($urandom);
      mem_write_ready = mem_write_valid ? (cnt == wait_n) : 1'($urandom);
      cnt++;
    end else begin
      cnt = 0;
      mem_read_ready  = 1'($urandom);
      mem_write_ready = 1'($urandom);
    end
  end

  task automatic issue(bit en, bit rd, bit wr, logic [7:0] rs, logic [7:0] rt, int w);
    seq.delete();
    wait_n = w;
    @(negedge clk);
    enable = en; mem_read_en = rd; mem_write_en = wr; rs_data = rs; rt_data = rt;
    core_state = REQUEST;
    @(posedge clk); #1;
    seq.push_back(int'(lsu_state));
    @(negedge clk);
    core_state = WAIT; mem_read_en = 0; mem_write_en = 0;
    rs_data = 8'($urandom); rt_data = 8'($urandom);
  endtask

  task automatic finish_op();
    int n = 0;
    while (seq[$] != 3 && n < 40) begin
      @(posedge clk); #1;
      seq.push_back(int'(lsu_state));
      n++;
    end
    if (seq[$] != 3) check("done_timeout", 32'(seq[$]), 3);
    @(negedge clk);
    core_state = UPDATE;
    @(posedge clk); #1;
    check("idle_after_update", 32'(lsu_state), 0);
    @(negedge clk);
    core_state = IDLE;
  endtask

  task automatic check_seq(string name, int exp[]);
    check({name, "_len"}, 32'(seq.size()), 32'(exp.size()));
    foreach (exp[i]) if (i < seq.size()) check(name, 32'(seq[i]), 32'(exp[i]));
  endtask

  initial begin
    rst_n = 1;
    #3 rst_n = 0;
    repeat (3) @(negedge clk);
    rst_n = 1;
    armed = 1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("reset_state", 32'(lsu_state), 0);
      check("reset_valid", 32'({mem_read_valid, mem_write_valid}), 0);
      check("reset_result", 32'(lsu_result), 0);
    end

    use_fixed = 1; fixed_data = 8'hA5;
    issue(1, 1, 0, 8'h12, 8'h00, 3);
    check("ldr_addr", 32'(mem_read_address), 32'h12);
    finish_op();
    check_seq("ldr_seq", '{1, 2, 2, 2, 3});
    check("ldr_result", 32'(lsu_result), 32'hA5);

    wv_cycles = 0;
    issue(1, 0, 1, 8'h40, 8'h7E, 0);
    check("str_wvalid", 32'(mem_write_valid), 1);
    check("str_addr", 32'(mem_write_address), 32'h40);
    check("str_data", 32'(mem_write_data), 32'h7E);
    finish_op();
    check_seq("str_seq", '{1, 3});
    check("str_wv_cycles", 32'(wv_cycles), 1);
    check("str_result_kept", 32'(lsu_result), 32'hA5);

    wv_cycles = 0; fixed_data = 8'h5A;
    issue(1, 1, 1, 8'h21, 8'h99, 1);
    check("both_rvalid", 32'(mem_read_valid), 1);
    check("both_wvalid", 32'(mem_write_valid), 0);
    finish_op();
    check("both_wv_cycles", 32'(wv_cycles), 0);
    check("both_result", 32'(lsu_result), 32'h5A);

    issue(0, 1, 0, 8'h33, 8'h00, 0);
    check("dis_state", 32'(lsu_state), 0);
    check("dis_valid", 32'({mem_read_valid, mem_write_valid}), 0);
    repeat (2) @(negedge clk);

    issue(1, 1, 0, 8'h55, 8'h00, 30);
    repeat (3) @(posedge clk);
    #2 check("pre_rst_state", 32'(lsu_state), 2);
    rst_n = 0;
    #1 check("rst_rvalid", 32'(mem_read_valid), 0);
    check("rst_state", 32'(lsu_state), 0);
    @(negedge clk);
    rst_n = 1;
    core_state = IDLE;
    fixed_data = 8'h3C;
    issue(1, 1, 0, 8'h03, 8'h00, 1);
    check("post_rst_addr", 32'(mem_read_address), 32'h03);
    finish_op();
    check_seq("post_rst_seq", '{1, 2, 3});
    check("post_rst_result", 32'(lsu_result), 32'h3C);

    use_fixed = 0;
    for (int k = 0; k < 200; k++) begin
      bit en, rd, wr;
      en = ($urandom_range(0, 7) != 0);
      rd = 1'($urandom); wr = 1'($urandom);
      issue(en, rd, wr, 8'($urandom), 8'($urandom), $urandom_range(0, 4));
      if (en && (rd || wr)) finish_op();
      else check("rand_noreq_state", 32'(lsu_state), 0);
      enable = 1'($urandom);
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/thread_lsu.md
# thread_lsu

Per-thread load/store unit that turns a decoded LDR/STR into a valid/ready transaction toward the memory controller. It produces the load result consumed by the thread's register file in the UPDATE stage. It takes its address and store data from the register file's rs/rt read ports. One instance sits beside each thread's ALU and register file inside a core.

## Interface
Parameters:
- DATA_WIDTH, 8, width of data words and of lsu_result
- ADDR_WIDTH, 8, width of memory addresses; the address is rs_data zero-extended or truncated to ADDR_WIDTH

Ports:
- clk  input  1  core clock; all state changes on rising edge
- rst_n  input  1  reset; asynchronous, active-low
- enable  input  1  thread active in current block; when low, unit stays IDLE
- core_state  input  core_state_t (gpu_pkg)  current core pipeline state
- mem_read_en  input  1  decoded LDR
- mem_write_en  input  1  decoded STR
- rs_data  input  DATA_WIDTH  address operand
- rt_data  input  DATA_WIDTH  store data operand
- mem_read_valid  output  1  read request valid
- mem_read_address  output  ADDR_WIDTH  read address
- mem_read_ready  input  1  read accepted, data returned this cycle
- mem_read_data  input  DATA_WIDTH  read data, valid when mem_read_ready
- mem_write_valid  output  1  write request valid
- mem_write_address  output  ADDR_WIDTH  write address
- mem_write_data  output  DATA_WIDTH  write data
- mem_write_ready  input  1  write accepted
- lsu_state  output  2  IDLE=0, REQUESTING=1, WAITING=2, DONE=3; the scheduler holds the core in WAIT while any thread reports 1 or 2
- lsu_result  output  DATA_WIDTH  last loaded word

## Operation
- All outputs are registered. Reset value of every output is 0, and lsu_state is IDLE.
- IDLE: on a rising edge with enable=1, core_state==REQUEST and (mem_read_en or mem_write_en):
  - go to REQUESTING;
  - latch address = rs_data[ADDR_WIDTH-1:0];
  - for a write, latch data = rt_data;
  - assert the matching valid.
- If mem_read_en and mem_write_en are both asserted, the read wins and the write is dropped.
- If both enables are low in REQUEST, stay IDLE. No request is issued.
- REQUESTING: lasts at least one cycle with valid high.
  - If ready is sampled high on that edge, go directly to DONE.
  - Otherwise go to WAITING.
- WAITING: hold valid, address and data stable until the first edge where ready=1, then go to DONE.
- Ready is honoured only for the operation in flight. mem_write_ready during a read, ready in IDLE or ready in DONE is ignored.
- On completion, deassert valid in the same edge that moves to DONE.
  - For a read, capture lsu_result <= mem_read_data.
  - A write leaves lsu_result unchanged.
- DONE: hold until an edge with core_state==UPDATE, then go to IDLE. The register file samples lsu_result during that UPDATE cycle, so lsu_result keeps its value after returning to IDLE.
- enable low:
  - in IDLE, no transition;
  - a transaction already in flight completes normally, because the handshake is never abandoned.
- Reset mid-transaction drops valid immediately (asynchronous) and returns the unit to IDLE. The memory controller is reset by the same rst_n.

## Timing
- Request issue: valid rises at the edge that samples core_state==REQUEST, one cycle after REQUEST is presented.
- Minimum latency is 1 cycle from valid high to DONE, when ready is high in the REQUESTING cycle. Latency with n wait cycles is n+1.
- lsu_result updates at the same edge that lsu_state becomes DONE.
- lsu_state and lsu_result are never both in flux in the UPDATE cycle.
- Back-to-back loads need IDLE for at least one cycle between them. REQUEST is never presented before UPDATE completes.

## Test plan
- Reset with rst_n=0, then release. Required: all outputs 0, lsu_state=0, no valid for 5 idle cycles.
- LDR, rs_data=0x12, with mem_read_ready=1 and mem_read_data=0xA5 three cycles after valid. Required: mem_read_address=0x12 held stable, states 1→2→2→2→3, lsu_result=0xA5, IDLE after UPDATE.
- STR, rs_data=0x40, rt_data=0x7E, with ready in the same cycle as REQUESTING. Required: write valid for exactly 1 cycle, address 0x40, data 0x7E, REQUESTING→DONE, lsu_result unchanged.
- mem_read_en and mem_write_en both high. Required: only mem_read_valid asserts, and mem_write_valid stays 0.
- enable=0 during REQUEST with mem_read_en=1. Required: no valid, lsu_state stays 0.
- rst_n pulsed low while in WAITING. Required: valid drops asynchronously, lsu_state=0, a later LDR to 0x03 completes normally.
